// File: rtl/dance_pkg.sv
// dance_pkg: definitions shared by the hit judge and the score/streak updater.
//   - JUDGE_* : 2-bit selector codes consumed by the score updater
//   - lane_state_e : per-lane judge FSM state
//   - abs_dist : absolute tick distance from the target instant
package dance_pkg;

  localparam logic [1:0] JUDGE_NONE    = 2'b00;
  localparam logic [1:0] JUDGE_OK      = 2'b01;
  localparam logic [1:0] JUDGE_PERFECT = 2'b10;
  localparam logic [1:0] JUDGE_MISS    = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } lane_state_e;

  function automatic int abs_dist(int count, int target);
    return (count > target) ? count - target : target - count;
  endfunction

endpackage

// File: rtl/lane_judge.sv
// lane_judge: one arrow lane. Arms on note_near, counts ticks while armed and
// grades the player's press against TARGET.
// Ports:
//   clk, reset (async, active low), tick, game_active (low = sync clear)
//   note_near, btn  : this lane's approach pulse and debounced button level
//   push_valid/push_code : one result to enqueue this cycle (combinational,
//                          so the FIFO captures it on the same edge as the press)
//   busy            : lane is ARMED (registered)
// Optional: GHOST_PENALTY_EN - a press on an idle lane pushes JUDGE_MISS.
module lane_judge
  import dance_pkg::*;
#(
  parameter int TARGET      = 100,
  parameter int PERFECT_TOL = 10,
  parameter int OK_TOL      = 30,
  parameter int CW          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       game_active,
  input  logic       note_near,
  input  logic       btn,
  output logic       push_valid,
  output logic [1:0] push_code,
  output logic       busy
);

  // Last legal count; a tick here means the note has timed out.
  localparam logic [CW-1:0] LAST = CW'(TARGET + OK_TOL);

  lane_state_e   state;
  logic [CW-1:0] count;
  logic          btn_q;
  logic          press;

  assign press = btn & ~btn_q;
  assign busy  = (state == ARMED);

  function automatic logic [1:0] grade(logic [CW-1:0] c);
    int d;
    d = abs_dist(int'(c), TARGET);
    if (d <= PERFECT_TOL) return JUDGE_PERFECT;
    if (d <= OK_TOL)      return JUDGE_OK;
    return JUDGE_MISS;  // only reachable when early; late presses time out first
  endfunction

  always_comb begin
    push_valid = 1'b0;
    push_code  = JUDGE_NONE;
    if (game_active) begin
      if (note_near) begin
        // Re-arm pre-empts the old note: it is a miss, and any press this
        // cycle belongs to nobody. From IDLE, a simultaneous press is judged
        // at count 0 against the freshly armed note.
        if (state == ARMED) begin
          push_valid = 1'b1;
          push_code  = JUDGE_MISS;
        end else if (press) begin
          push_valid = 1'b1;
          push_code  = grade('0);
        end
      end else if (state == ARMED) begin
        if (press) begin
          push_valid = 1'b1;
          push_code  = grade(count);
        end else if (tick && count == LAST) begin
          push_valid = 1'b1;
          push_code  = JUDGE_MISS;
        end
      end
`ifdef GHOST_PENALTY_EN
      else if (press) begin
        push_valid = 1'b1;
        push_code  = JUDGE_MISS;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      btn_q <= 1'b0;
    end else if (!game_active) begin
      state <= IDLE;
      count <= '0;
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn;
      if (note_near) begin
        count <= '0;
        state <= (state == IDLE && press) ? IDLE : ARMED;
      end else if (state == ARMED) begin
        if (press || (tick && count == LAST)) begin
          state <= IDLE;
          count <= '0;
        end else if (tick) begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hit_judge.sv
// hit_judge: per-lane dance-arrow timing judge feeding the score/streak updater.
// Ports:
//   clk, reset (async, active low), tick (timebase strobe), game_active
//   note_near[LANES], btn[LANES] : per-lane approach pulses / button levels
//   selector  : one-cycle judge code (00 none, 01 ok, 10 perfect, 11 miss/bad)
//   lane_busy : per-lane ARMED flags
//   overflow  : sticky, a result was dropped on a full FIFO
// Optional: GHOST_PENALTY_EN (see lane_judge).
// Same-cycle pushes enter the FIFO in ascending lane order; free space is
// measured before this cycle's pop, so a pop never makes room for a push.
module hit_judge
  import dance_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int TARGET      = 100,
  parameter int PERFECT_TOL = 10,
  parameter int OK_TOL      = 30,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             game_active,
  input  logic [LANES-1:0] note_near,
  input  logic [LANES-1:0] btn,
  output logic [1:0]       selector,
  output logic [LANES-1:0] lane_busy,
  output logic             overflow
);

  localparam int            CW      = $clog2(TARGET + OK_TOL + 2);
  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   DEPTH_W = (PW+1)'(FIFO_DEPTH);

  logic [LANES-1:0]         push_valid;
  logic [LANES-1:0][1:0]    push_code;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_judge #(
      .TARGET(TARGET), .PERFECT_TOL(PERFECT_TOL), .OK_TOL(OK_TOL), .CW(CW)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .game_active(game_active),
      .note_near  (note_near[g]),
      .btn        (btn[g]),
      .push_valid (push_valid[g]),
      .push_code  (push_code[g]),
      .busy       (lane_busy[g])
    );
  end

  logic [1:0]               mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [PW:0]              used, free, n_acc;
  logic [LANES-1:0]         accept;
  logic [LANES-1:0][PW-1:0] slot;
  logic                     drop, pop;

  assign pop = (used != '0);

  // Pack accepted pushes into consecutive slots after wr_ptr.
  always_comb begin
    free   = DEPTH_W - used;
    n_acc  = '0;
    accept = '0;
    slot   = '0;
    drop   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (push_valid[i]) begin
        if (n_acc < free) begin
          accept[i] = 1'b1;
          slot[i]   = wr_ptr + n_acc[PW-1:0];
          n_acc     = n_acc + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (accept[i]) mem[slot[i]] <= push_code[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      used     <= '0;
      selector <= JUDGE_NONE;
      overflow <= 1'b0;
    end else if (!game_active) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      used     <= '0;
      selector <= JUDGE_NONE;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + n_acc[PW-1:0];
      used   <= used + n_acc - {{PW{1'b0}}, pop};
      if (pop) begin
        selector <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end else begin
        selector <= JUDGE_NONE;
      end
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
module tb_hit_judge;
  import dance_pkg::*;

  localparam int LANES = 4, TARGET = 100, PT = 10, OT = 30, DEPTH = 4;

  logic             clk = 1'b0, reset = 1'b0, tick = 1'b0, game_active = 1'b0;
  logic [LANES-1:0] note_near = '0, btn = '0;
  logic [1:0]       selector;
  logic [LANES-1:0] lane_busy;
  logic             overflow;

  hit_judge #(.LANES(LANES), .TARGET(TARGET), .PERFECT_TOL(PT), .OK_TOL(OT),
              .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .tick(tick), .game_active(game_active),
    .note_near(note_near), .btn(btn), .selector(selector),
    .lane_busy(lane_busy), .overflow(overflow));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model: notes as (armed, elapsed ticks), results as a queue.
  bit m_armed [LANES];
  int m_cnt   [LANES];
  bit m_bprev [LANES];
  int m_q [$];
  int m_sel;
  bit m_ovf;

  function automatic int judge(int c);
    int d;
    d = (c > TARGET) ? c - TARGET : TARGET - c;
    if (d <= PT) return 2;
    if (d <= OT) return 1;
    return 3;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LANES; i++) begin
      m_armed[i] = 0; m_cnt[i] = 0; m_bprev[i] = 0;
    end
    m_q.delete();
    m_sel = 0;
    m_ovf = 0;
  endfunction

  function automatic void model_step();
    int ev [$];
    int free, code;
    bit press;
    if (!game_active) begin
      model_clear();
      return;
    end
    free = DEPTH - m_q.size();
    for (int i = 0; i < LANES; i++) begin
      press = btn[i] && !m_bprev[i];
      m_bprev[i] = btn[i];
      code = 0;
      if (note_near[i]) begin
        if (m_armed[i]) begin
          code = 3; m_cnt[i] = 0;
        end else if (press) begin
          code = judge(0);
        end else begin
          m_armed[i] = 1; m_cnt[i] = 0;
        end
      end else if (m_armed[i] && press) begin
        code = judge(m_cnt[i]); m_armed[i] = 0;
      end else if (m_armed[i] && tick) begin
        if (m_cnt[i] + 1 > TARGET + OT) begin
          code = 3; m_armed[i] = 0;
        end else begin
          m_cnt[i]++;
        end
      end else if (!m_armed[i] && press) begin
`ifdef GHOST_PENALTY_EN
        code = 3;
`endif
      end
      if (code != 0) ev.push_back(code);
    end
    m_sel = (m_q.size() > 0) ? m_q.pop_front() : 0;
    for (int k = 0; k < ev.size(); k++) begin
      if (k < free) m_q.push_back(ev[k]);
      else m_ovf = 1;
    end
  endfunction

  function automatic int model_busy();
    int b = 0;
    for (int i = 0; i < LANES; i++) if (m_armed[i]) b |= (1 << i);
    return b;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: DUT and model see the same inputs, outputs compared #1 later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("model_sel",  int'(selector),  m_sel);
    chk("model_busy", int'(lane_busy), model_busy());
    chk("model_ovf",  int'(overflow),  int'(m_ovf));
  endtask

  typedef struct {
    int lane;
    int cnt;
    int exp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{0, 100, int'(JUDGE_PERFECT)};
    tbl[1]  = '{1, 110, int'(JUDGE_PERFECT)};
    tbl[2]  = '{2,  90, int'(JUDGE_PERFECT)};
    tbl[3]  = '{3, 111, int'(JUDGE_OK)};
    tbl[4]  = '{0,  89, int'(JUDGE_OK)};
    tbl[5]  = '{1, 125, int'(JUDGE_OK)};
    tbl[6]  = '{2, 130, int'(JUDGE_OK)};
    tbl[7]  = '{3,  70, int'(JUDGE_OK)};
    tbl[8]  = '{0,  69, int'(JUDGE_MISS)};
    tbl[9]  = '{1,  60, int'(JUDGE_MISS)};
    tbl[10] = '{2,   0, int'(JUDGE_MISS)};

    model_clear();
    #12;
    chk("reset_sel",  int'(selector),  0);
    chk("reset_busy", int'(lane_busy), 0);
    chk("reset_ovf",  int'(overflow),  0);
    @(negedge clk);
    reset = 1'b1;
    game_active = 1'b1;
    tick = 1'b1;
    cycle();

    // Press timing table, tick every clock.
    for (int v = 0; v < 11; v++) begin
      note_near[tbl[v].lane] = 1'b1;
      cycle();
      note_near = '0;
      chk($sformatf("tbl%0d_armed", v), int'(lane_busy[tbl[v].lane]), 1);
      repeat (tbl[v].cnt) cycle();
      btn[tbl[v].lane] = 1'b1;
      cycle();
      chk($sformatf("tbl%0d_busy_fall", v), int'(lane_busy[tbl[v].lane]), 0);
      chk($sformatf("tbl%0d_latency", v), int'(selector), 0);
      btn = '0;
      cycle();
      chk($sformatf("tbl%0d_code", v), int'(selector), tbl[v].exp);
      cycle();
      chk($sformatf("tbl%0d_one_cycle", v), int'(selector), 0);
    end

    // Timeout on lane 2.
    note_near[2] = 1'b1;
    cycle();
    note_near = '0;
    repeat (130) cycle();
    chk("timeout_still_armed", int'(lane_busy[2]), 1);
    cycle();
    chk("timeout_busy", int'(lane_busy[2]), 0);
    chk("timeout_pre", int'(selector), 0);
    cycle();
    chk("timeout_sel", int'(selector), 3);

    // All four lanes perfect in the same cycle.
    note_near = 4'hF;
    cycle();
    note_near = '0;
    repeat (100) cycle();
    btn = 4'hF;
    cycle();
    btn = '0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk($sformatf("quad_perfect%0d", k), int'(selector), 2);
    end
    cycle();
    chk("quad_done", int'(selector), 0);
    chk("quad_ovf", int'(overflow), 0);

    // Fill the FIFO with four re-arm misses, then two early presses overflow.
    note_near = 4'hF;
    cycle();
    cycle();
    note_near = '0;
    btn = 4'b0011;
    cycle();
    btn = '0;
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_pop0", int'(selector), 3);
    for (int k = 1; k < 4; k++) begin
      cycle();
      chk($sformatf("ovf_pop%0d", k), int'(selector), 3);
    end
    cycle();
    chk("ovf_dropped", int'(selector), 0);
    repeat (5) cycle();
    chk("ovf_sticky", int'(overflow), 1);
    game_active = 1'b0;
    cycle();
    chk("ovf_clear", int'(overflow), 0);
    chk("ga_busy_clear", int'(lane_busy), 0);
    game_active = 1'b1;
    cycle();

    // Press on an idle lane.
    btn[3] = 1'b1;
    cycle();
    btn = '0;
    cycle();
`ifdef GHOST_PENALTY_EN
    chk("ghost_sel", int'(selector), 3);
`else
    chk("ghost_sel", int'(selector), 0);
`endif
    cycle();

    // Async reset while lane 0 is armed and a code is on the selector.
    note_near = 4'b0011;
    cycle();
    note_near = '0;
    repeat (5) cycle();
    btn[1] = 1'b1;
    cycle();
    btn = '0;
    cycle();
    chk("pre_rst_sel", int'(selector), 3);
    chk("pre_rst_busy", int'(lane_busy[0]), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_sel",  int'(selector),  0);
    chk("async_rst_busy", int'(lane_busy), 0);
    chk("async_rst_ovf",  int'(overflow),  0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      game_active = ($urandom_range(0, 399) != 0);
      tick = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < LANES; i++) begin
        note_near[i] = ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Per-lane timing judge for dance-arrow notes. It sits directly upstream of the score/streak updater and produces that updater's 2-bit selector.
- Each lane arms on a note-approach pulse and times the player's press against the target instant in tick units.
- It classifies each note as perfect, ok, bad or miss. Results are queued in a small FIFO and emitted as one-cycle selector codes, at most one per clock.

Parameters:
- LANES, 4, number of arrow lanes.
- TARGET, 100, ticks from note_near to the ideal hit instant.
- PERFECT_TOL, 10, max |count-TARGET| for a perfect judgement.
- OK_TOL, 30, max |count-TARGET| for an ok judgement. Legal only if PERFECT_TOL <= OK_TOL < TARGET.
- FIFO_DEPTH, 4, result queue entries (power of 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  timebase strobe, one clk wide (e.g. 1 kHz).
- game_active  in  1  high while a song plays.
- note_near  in  LANES  per-lane pulse: a note has entered the judging window.
- btn  in  LANES  per-lane button level, already synchronised and debounced.
- selector  out  2  00 none, 01 ok, 10 perfect, 11 miss/bad. One clk per event.
- lane_busy  out  LANES  lane is armed.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.

Behaviour:
- Reset (reset low, async): all lanes IDLE, counters 0, FIFO empty, selector=00, lane_busy=0, overflow=0, btn history=0.
- game_active low: same clearing as reset, applied synchronously; inputs are ignored.
- Press = rising edge of btn[i], detected against a registered copy.
- Counter width = clog2(TARGET+OK_TOL+2).
- Lane FSM states: IDLE, ARMED.
  - IDLE to ARMED on note_near[i]. Count loads 0.
  - In ARMED, count increments on tick.
- Judgement of a press in ARMED, using the count value current in that cycle:
  - |count-TARGET| <= PERFECT_TOL: push 10.
  - Otherwise, |count-TARGET| <= OK_TOL: push 01.
  - Otherwise (count < TARGET-OK_TOL): too early, push 11.
  - After any of these, go to IDLE.
- Timeout: in ARMED, when a tick would make count = TARGET+OK_TOL+1, push 11 and go to IDLE. The counter never wraps.
- note_near while ARMED: the pending note is judged a miss (push 11) and the lane re-arms with count=0. The same lane cannot push twice in one cycle, because the re-arm pre-empts the old note's press/timeout.
- note_near and press on the same lane in the same cycle while IDLE: the lane arms first, then the press is judged at count 0, giving an early 11.
- Press while IDLE: no event (see optional feature).
- Multiple lanes in one cycle push in ascending lane index.
  - Pushes beyond free space are dropped, and overflow is set.
  - Free space is computed before this cycle's pop.
- Pop: one entry per clk when non-empty. The popped code is registered onto selector for exactly one cycle; otherwise selector=00.
- Latency: a press edge sampled at clock edge k, with the FIFO empty, produces its selector code in the cycle after edge k+1.
- overflow clears only on reset or game_active low.

Optional Feature:
- Macro: GHOST_PENALTY_EN.
- Defined: a press on an IDLE lane pushes 11 (resets the streak downstream), following the same ordering and overflow rules as other pushes.
- Undefined: presses on IDLE lanes are ignored.

Decomposition:
- Shared package dance_pkg holds:
  - judge-code constants JUDGE_NONE=2'b00, JUDGE_OK=2'b01, JUDGE_PERFECT=2'b10, JUDGE_MISS=2'b11, shared with the score updater;
  - the lane-state enum (IDLE, ARMED);
  - a helper function for the absolute distance from TARGET.
- Sub-module lane_judge: one per lane, generated LANES times. It holds the FSM, counter and edge detector, and outputs push_valid and push_code.
- The top level contains the ordered multi-push FIFO and the selector register.

Test Plan:
- note_near[0], tick every clk, press at count 100: selector=10 for exactly one cycle two clks later; lane_busy[0] falls.
- Press at count 125: selector=01. Press at count 60: selector=11.
- note_near[2] with no press: selector=11 when count would reach 131; lane_busy[2]=0 afterwards.
- All 4 lanes perfect in the same cycle with the FIFO empty: selector=10 on four consecutive cycles, then 00; overflow=0.
- Fill the FIFO with 4 entries while 2 more events arrive in the same cycle: the extra entries are dropped, overflow=1 and stays 1 until game_active is dropped.
- Press on an idle lane: selector stays 00 without GHOST_PENALTY_EN, and is 11 with it. Asserting reset low mid-ARMED: all outputs 0 immediately (asynchronously).
